// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches that drive
// the 1101 sequence detector from it.
package seqgen_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP   = 2;

  // Default detector stimulus: 1101 sent as a 4-bit pattern.
  localparam logic [DEF_WIDTH-1:0] PATTERN_1101     = 8'b0000_1101;
  localparam int                   PATTERN_1101_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: shifts a loaded pattern out MSB-first, repeated
// reps+1 times with GAP idle cycles between repeats.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  output logic                       x,
  output logic                       x_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   pattern_q, pattern_n;
  logic [IDX_W-1:0]   last_q, last_n;
  logic [IDX_W-1:0]   idx, idx_n, idx_dec;
  logic [IDX_W-1:0]   len_last;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_n;
  logic               x_n, x_valid_n, done_n;

  // Index of the first bit to send: len of 0 or above WIDTH means a full word.
  always_comb begin
    if (len == '0 || len > LEN_W'(WIDTH))
      len_last = IDX_W'(WIDTH - 1);
    else
      len_last = IDX_W'(len - 1'b1);
  end

  assign idx_dec = idx - 1'b1;

  always_comb begin
    // NOTE: every next-state variable is defaulted first so no latch is inferred.
    state_n   = state;
    pattern_n = pattern_q;
    last_n    = last_q;
    idx_n     = idx;
    gap_cnt_n = gap_cnt;
    rep_cnt_n = rep_cnt;
    x_n       = 1'b0;
    x_valid_n = 1'b0;
    done_n    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (load_valid) begin
          state_n   = ST_SHIFT;
          pattern_n = pattern;
          last_n    = len_last;
          idx_n     = len_last;
          rep_cnt_n = reps;
          x_n       = pattern[len_last];
          x_valid_n = 1'b1;
        end
      end

      // idx names the bit currently on x; outputs are computed one cycle ahead.
      ST_SHIFT: begin
        if (idx != '0) begin
          idx_n     = idx_dec;
          x_n       = pattern_q[idx_dec];
          x_valid_n = 1'b1;
        end else if (rep_cnt != '0) begin
          rep_cnt_n = rep_cnt - 1'b1;
          if (GAP > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = GAP_W'(GAP - 1);
          end else begin
            idx_n     = last_q;
            x_n       = pattern_q[last_q];
            x_valid_n = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_n   = ST_SHIFT;
          idx_n     = last_q;
          x_n       = pattern_q[last_q];
          x_valid_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pattern_q  <= '0;
      last_q     <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      rep_cnt    <= '0;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_n;
      pattern_q  <= pattern_n;
      last_q     <= last_n;
      idx        <= idx_n;
      gap_cnt    <= gap_cnt_n;
      rep_cnt    <= rep_cnt_n;
      x          <= x_n;
      x_valid    <= x_valid_n;
      done       <= done_n;
      busy       <= (state_n != ST_IDLE);
      load_ready <= (state_n == ST_IDLE);
    end
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial bit-pattern transmitter: the driving end for the serial `x` input of the 1101-style sequence detector. A host loads a pattern word, a length and a repeat count through a valid/ready handshake. The block shifts the pattern out MSB-first, one bit per clock, with an idle gap between repeats. It is used as the stimulus source for detector testing and as the on-chip pattern source in the serial-link path.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `REP_W`, 4: width of the repeat-count field.
- `GAP`, 2: idle cycles inserted between repeats; 0 is legal and gives back-to-back repeats.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- `load_valid`  in  1  host offers a job.
- `load_ready`  out  1  block accepts a job; high only in IDLE.
- `pattern`  in  WIDTH  pattern bits; the bit at index `len-1` is sent first and bit 0 last.
- `len`  in  $clog2(WIDTH+1)  bits to send; 0 means WIDTH; values above WIDTH are clamped to WIDTH.
- `reps`  in  REP_W  extra repeats; total transmissions = `reps`+1.
- `x`  out  1  serial data; registered; 0 whenever `x_valid`=0.
- `x_valid`  out  1  high exactly in the cycles that carry pattern bits.
- `busy`  out  1  high in SHIFT and GAP.
- `done`  out  1  one-cycle pulse after the last bit of the last repeat.

## Operation
- States: IDLE, SHIFT, GAP. Encoding lives in the package.
- IDLE: `load_ready`=1. When `load_valid`=1 at an edge, capture `pattern`, effective length `L`, and `reps` into a remaining-repeat counter. Then go to SHIFT with bit index `L-1`.
- SHIFT: each cycle drive `x`=`pattern_q[idx]` and `x_valid`=1, then decrement `idx`. After idx 0:
  - if remaining repeats > 0 and GAP > 0: go to GAP and decrement the repeat counter;
  - if remaining repeats > 0 and GAP = 0: reload `idx`=`L-1`, stay in SHIFT, decrement the counter;
  - otherwise go to IDLE and pulse `done`.
- GAP: `x`=0 and `x_valid`=0 for exactly GAP cycles. Then reload `idx`=`L-1` and return to SHIFT.
- `load_valid` outside IDLE is ignored. `pattern`, `len` and `reps` are sampled only at the accept edge.
- Bits of `pattern` above `L-1` are don't-care.
- Reset, including mid-SHIFT or mid-GAP, outputs immediately: `x`=0, `x_valid`=0, `busy`=0, `done`=0, `load_ready`=1, state IDLE. A partially sent pattern is discarded.
- Counters: the bit index is $clog2(WIDTH) wide, the gap counter is $clog2(GAP+1) wide, and the repeat counter is REP_W wide. None of them wraps, because each is reloaded or exited at zero.

## Timing
- The job is accepted at edge T. The first bit appears on `x` and `x_valid` in cycle T+1.
- Each transmission occupies `L` consecutive `x_valid` cycles.
- Total busy cycles: (reps+1)·L + reps·GAP.
- `done`=1 and `load_ready`=1 in the cycle after the final bit, and `busy` falls in that same cycle.
- A new job is accepted at the edge ending the `done` cycle. Its first bit follows one cycle later, so there is exactly one idle cycle between jobs.
- `load_ready` is a registered state decode with no combinational path from `load_valid`.

## Structure
- Shared package `seqgen_pkg`: the state enum (IDLE, SHIFT, GAP) and default constants for WIDTH, REP_W and GAP. The detector test bench reuses the default 1101 pattern constant defined there.
- Flat module with one FSM and three counters; no sub-module is needed.

## Test plan
- Reset: assert `reset` mid-cycle during SHIFT -> `x`, `x_valid`, `busy` drop to 0 asynchronously; after release `load_ready`=1.
- Single pattern: `pattern`=8'b0000_1101, `len`=4, `reps`=0 -> `x`=1,1,0,1 with `x_valid` high for 4 cycles starting T+1; `done` at T+5.
- Repeat with gap: same pattern, `reps`=1, GAP=2 -> 1,1,0,1, then two cycles of 0 with `x_valid`=0, then 1,1,0,1; `done` at T+11. The connected detector raises `y` twice.
- Boundaries: `len`=0 sends all 8 bits of 8'hA5 as 1,0,1,0,0,1,0,1. `len`=1 with `pattern`=1 sends a single 1.
- GAP=0 with `reps`=2 and pattern 101 (len 3) -> 9 contiguous `x_valid` cycles: 101101101.
- Handshake: hold `load_valid` high continuously -> jobs are accepted only in IDLE, and a mid-job change to `pattern` does not alter the output.
